// File: rtl/rf_wb_queue.sv
// In-order write-back queue feeding the register file's single write port.
// Define RF_WB_FWD_EN to enable forwarding of pending writes to the read ports.
module rf_wb_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_vld,
    output logic          alu_rdy,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_vld,
    output logic          ld_rdy,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    input  logic          wb_hold,
    input  logic          hlt,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst,
    output logic          we,
    input  logic [AW-1:0] p0_addr,
    input  logic [AW-1:0] p1_addr,
    output logic          fwd0_hit,
    output logic [DW-1:0] fwd0_data,
    output logic          fwd1_hit,
    output logic [DW-1:0] fwd1_data,
    output logic [CW-1:0] count,
    output logic          drained
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          acc_ld;
    logic          acc_alu;
    logic          push;
    logic          pop;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign ld_rdy  = ~hlt & (count < CW'(DEPTH));
    assign alu_rdy = ld_rdy & ~ld_vld;

    assign acc_ld    = ld_vld & ld_rdy;
    assign acc_alu   = alu_vld & alu_rdy;
    assign push_addr = acc_ld ? ld_addr : alu_addr;
    assign push_data = acc_ld ? ld_data : alu_data;
    assign push      = (acc_ld | acc_alu) & (push_addr != '0);
    assign pop       = (count != '0) & ~wb_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            we       <= 1'b0;
            dst_addr <= '0;
            dst      <= '0;
            drained  <= 1'b0;
        end else begin
            drained <= hlt & (count == '0) & ~we;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                dst_addr <= q_addr[rd_ptr];
                dst      <= q_data[rd_ptr];
                we       <= 1'b1;
            end else begin
                we <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage needs no reset: validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= push_addr;
            q_data[wr_ptr] <= push_data;
        end
    end

`ifdef RF_WB_FWD_EN
    // Scan output stage, then oldest to newest entry, so the newest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        fwd0_hit  = 1'b0;
        fwd0_data = '0;
        fwd1_hit  = 1'b0;
        fwd1_data = '0;
        idx       = '0;
        if (we && dst_addr == p0_addr) begin
            fwd0_hit  = 1'b1;
            fwd0_data = dst;
        end
        if (we && dst_addr == p1_addr) begin
            fwd1_hit  = 1'b1;
            fwd1_data = dst;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (q_addr[idx] == p0_addr) begin
                    fwd0_hit  = 1'b1;
                    fwd0_data = q_data[idx];
                end
                if (q_addr[idx] == p1_addr) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = q_data[idx];
                end
            end
        end
        if (p0_addr == '0) begin
            fwd0_hit  = 1'b0;
            fwd0_data = '0;
        end
        if (p1_addr == '0) begin
            fwd1_hit  = 1'b0;
            fwd1_data = '0;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{p0_addr, p1_addr};
    assign fwd0_hit   = 1'b0;
    assign fwd0_data  = '0;
    assign fwd1_hit   = 1'b0;
    assign fwd1_data  = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios then random traffic
// against a queue-based reference model.
module tb_rf_wb_queue;

    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_vld, alu_rdy, ld_vld, ld_rdy;
    logic [AW-1:0] alu_addr, ld_addr, dst_addr, p0_addr, p1_addr;
    logic [DW-1:0] alu_data, ld_data, dst, fwd0_data, fwd1_data;
    logic          wb_hold, hlt, we, fwd0_hit, fwd1_hit, drained;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    rf_wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .alu_vld(alu_vld), .alu_rdy(alu_rdy),
        .alu_addr(alu_addr), .alu_data(alu_data),
        .ld_vld(ld_vld), .ld_rdy(ld_rdy),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .wb_hold(wb_hold), .hlt(hlt),
        .dst_addr(dst_addr), .dst(dst), .we(we),
        .p0_addr(p0_addr), .p1_addr(p1_addr),
        .fwd0_hit(fwd0_hit), .fwd0_data(fwd0_data),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .count(count), .drained(drained)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    logic          m_we;
    logic [AW-1:0] m_a;
    logic [DW-1:0] m_d;
    logic          m_drained;
    int            vectors = 0;
    int            fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fwd_ref(input logic [AW-1:0] p, output logic hit,
                           output logic [DW-1:0] data);
        hit  = 1'b0;
        data = '0;
`ifdef RF_WB_FWD_EN
        if (p != 0) begin
            if (m_we && m_a == p) begin
                hit  = 1'b1;
                data = m_d;
            end
            foreach (q[i]) begin
                if (q[i].a == p) begin
                    hit  = 1'b1;
                    data = q[i].d;
                end
            end
        end
`endif
    endtask

    task automatic cycle();
        logic          er, ld_acc, alu_acc, h;
        logic [DW-1:0] d;
        ent_t          e;
        #1;
        er = !hlt && q.size() < DEPTH;
        chk("ld_rdy", ld_rdy, er);
        chk("alu_rdy", alu_rdy, er && !ld_vld);
        fwd_ref(p0_addr, h, d);
        chk("fwd0_hit", fwd0_hit, h);
        chk("fwd0_data", fwd0_data, d);
        fwd_ref(p1_addr, h, d);
        chk("fwd1_hit", fwd1_hit, h);
        chk("fwd1_data", fwd1_data, d);
        ld_acc  = ld_vld && er;
        alu_acc = alu_vld && er && !ld_vld;
        @(posedge clk);
        m_drained = hlt && q.size() == 0 && !m_we;
        if (q.size() > 0 && !wb_hold) begin
            e    = q.pop_front();
            m_we = 1'b1;
            m_a  = e.a;
            m_d  = e.d;
        end else begin
            m_we = 1'b0;
        end
        if (ld_acc && ld_addr != 0) q.push_back('{ld_addr, ld_data});
        else if (alu_acc && alu_addr != 0) q.push_back('{alu_addr, alu_data});
        #1;
        chk("we", we, m_we);
        chk("dst_addr", dst_addr, m_a);
        chk("dst", dst, m_d);
        chk("count", count, q.size());
        chk("drained", drained, m_drained);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        m_we = 0; m_a = 0; m_d = 0; m_drained = 0;
        chk("rst_we", we, 0);
        chk("rst_count", count, 0);
        chk("rst_drained", drained, 0);
        chk("rst_dst_addr", dst_addr, 0);
        chk("rst_dst", dst, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        alu_vld = 0;
        ld_vld  = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic alu_push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        alu_vld = 1; alu_addr = a; alu_data = d;
        cycle();
        alu_vld = 0;
    endtask

    initial begin
        rst = 1; alu_vld = 0; ld_vld = 0; wb_hold = 0; hlt = 0;
        alu_addr = 0; alu_data = 0; ld_addr = 0; ld_data = 0;
        p0_addr = 0; p1_addr = 0;
        @(negedge clk);
        do_reset();

        alu_push(4'd3, 16'h1234);
        cycle();
        chk("t1_we", we, 1);
        chk("t1_addr", dst_addr, 3);
        chk("t1_dst", dst, 16'h1234);
        idle(2);

        ld_vld = 1; ld_addr = 2; ld_data = 16'h5555;
        alu_vld = 1; alu_addr = 1; alu_data = 16'hAAAA;
        cycle();
        ld_vld = 0;
        cycle();
        chk("t2_first", dst_addr, 2);
        alu_vld = 0;
        cycle();
        chk("t2_second", dst_addr, 1);
        idle(2);

        wb_hold = 1;
        for (int i = 0; i < 4; i++) alu_push(AW'(i + 6), DW'(16'h0100 + i));
        idle(1);
        chk("t3_count", count, 4);
        wb_hold = 0;
        idle(6);

        alu_push(4'd0, 16'hFFFF);
        idle(3);
        chk("t4_count", count, 0);

        wb_hold = 1;
        alu_push(4'd5, 16'h1111);
        alu_push(4'd5, 16'h2222);
        p0_addr = 5; p1_addr = 5;
        idle(1);
`ifdef RF_WB_FWD_EN
        chk("t5_hit", fwd0_hit, 1);
        chk("t5_data", fwd1_data, 16'h2222);
`endif
        p0_addr = 0;
        idle(1);
        wb_hold = 0;
        p0_addr = 5;
        idle(4);
        p0_addr = 0; p1_addr = 0;

        wb_hold = 1;
        for (int i = 0; i < 3; i++) alu_push(AW'(i + 9), DW'(16'h0300 + i));
        hlt = 1; wb_hold = 0;
        alu_vld = 1; alu_addr = 4; alu_data = 16'hDEAD;
        cycle();
        idle(6);
        chk("t6_drained", drained, 1);
        hlt = 0;
        idle(1);

        wb_hold = 1;
        for (int i = 0; i < 3; i++) alu_push(AW'(i + 12), DW'(16'h0600 + i));
        hlt = 1; wb_hold = 0;
        idle(1);
        @(posedge clk);
        #2;
        do_reset();
        idle(4);
        hlt = 0;
        idle(1);

        for (int n = 0; n < 400; n++) begin
            ld_vld   = ($urandom % 3) == 0;
            alu_vld  = ($urandom % 2) == 0;
            ld_addr  = AW'($urandom);
            alu_addr = AW'($urandom);
            ld_data  = DW'($urandom);
            alu_data = DW'($urandom);
            wb_hold  = ($urandom % 4) == 0;
            hlt      = ($urandom % 12) == 0;
            p0_addr  = AW'($urandom);
            p1_addr  = AW'($urandom);
            if (($urandom % 150) == 0) do_reset();
            else cycle();
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
